// File: rtl/i2c_target.sv
// I2C register target: 7-bit address, 8-bit auto-incrementing register pointer.
// Bus inputs are synchronized into clk; all protocol logic works on edges seen there.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic scl_h_q, sda_h_q;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start, stop;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_req_q, rd_req_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        busy_q, busy_d;
  logic [7:0]  rx_byte;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  assign start = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop  = scl_s & scl_h_q & ~sda_h_q & sda_s;
  assign rx_byte = {shift_q[6:0], sda_s};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;

    // Read data arrives the cycle after the request.
    if (rd_req_q) shift_d = rd_data;

    if (stop) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_rise && state_q == ADDR_ACK
              && rw_q && sda_oe_q) begin
            rd_req_d  = 1'b1;
            rd_addr_d = ptr_q;
          end
          // First fall drives ACK, second fall ends the slot.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if (state_q == ADDR_ACK) begin
                if (rw_q) begin
                  state_d  = RDATA;
                  sda_oe_d = ~shift_q[7];
                end else begin
                  state_d = REG;
                end
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        REG: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            ptr_d   = rx_byte;
            state_d = REG_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_byte;
            ptr_d     = ptr_q + 8'd1;
            state_d   = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d     = ptr_q + 8'd1;
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q + 8'd1;
            end else begin
              state_d = WAIT;
            end
          end else if (scl_fall) begin
            state_d  = RDATA;
            cnt_d    = 4'd0;
            sda_oe_d = ~shift_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_h_q    <= scl_s;
      sda_h_q    <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, register-file model and
// a transaction-level reference of the register map and pointer.
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h1A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_oe, wr_en, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  logic [7:0]  regs [256];
  logic [7:0]  ref_regs [256];
  logic [7:0]  ref_ptr;
  logic [15:0] wr_q [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  exp_rd [$];
  logic        busy_seen, oe_seen, wr_prev;
  int          n_chk = 0;
  int          n_err = 0;

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;
  assign rd_data = regs[rd_addr];

  i2c_target #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_prev) chk("wr_width", 32'(wr_en), 32'd0);
    wr_prev = wr_en;
    if (wr_en) begin
      wr_q.push_back({wr_addr, wr_data});
      regs[wr_addr] = wr_data;
    end
    if (rd_req) rd_q.push_back(rd_addr);
    if (busy) busy_seen = 1'b1;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    sda_m = 1'b1; scl_m = 1'b1; wt(8);
    sda_m = 1'b0; wt(8);
    scl_m = 1'b0;
  endtask

  task automatic m_rstart();
    wt(4); sda_m = 1'b1; wt(4);
    scl_m = 1'b1; wt(8);
    sda_m = 1'b0; wt(8);
    scl_m = 1'b0;
  endtask

  task automatic m_stop();
    wt(4); sda_m = 1'b0; wt(4);
    scl_m = 1'b1; wt(8);
    sda_m = 1'b1; wt(8);
  endtask

  task automatic m_bit(input logic b);
    wt(4); sda_m = b; wt(4);
    scl_m = 1'b1; wt(8);
    scl_m = 1'b0;
  endtask

  task automatic m_rbit(output logic b);
    wt(4); sda_m = 1'b1; wt(4);
    scl_m = 1'b1; wt(4);
    b = sda_in; wt(4);
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    m_rbit(bit_v);
    ack = ~bit_v;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic bit_v;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(bit_v);
      b[i] = bit_v;
    end
    m_bit(~mack);
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [7:0] ptr,
                          input int n, input logic [7:0] dat [4],
                          input logic partial);
    logic ack, hit;
    hit = (dev == DEV);
    wr_q.delete(); exp_wr.delete();
    busy_seen = 1'b0; oe_seen = 1'b0;
    m_start();
    send_byte({dev, 1'b0}, ack);
    chk("addr_ack", 32'(ack), 32'(hit));
    send_byte(ptr, ack);
    chk("reg_ack", 32'(ack), 32'(hit));
    if (hit) ref_ptr = ptr;
    for (int i = 0; i < n; i++) begin
      send_byte(dat[i], ack);
      chk("data_ack", 32'(ack), 32'(hit));
      if (hit) begin
        exp_wr.push_back({ref_ptr, dat[i]});
        ref_regs[ref_ptr] = dat[i];
        ref_ptr = ref_ptr + 8'd1;
      end
    end
    if (partial)
      for (int i = 0; i < 4; i++) m_bit(1'($urandom_range(1)));
    m_stop(); wt(4);
    chk("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      chk("wr_beat", 32'(wr_q[i]), 32'(exp_wr[i]));
    chk("busy_seen", 32'(busy_seen), 32'(hit));
    chk("busy_after_stop", 32'(busy), 32'd0);
    if (!hit) chk("oe_quiet", 32'(oe_seen), 32'd0);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ptr,
                         input int n);
    logic ack;
    logic [7:0] d;
    rd_q.delete(); exp_rd.delete();
    m_start();
    if (set_ptr) begin
      send_byte({DEV, 1'b0}, ack);
      chk("rs_addr_ack", 32'(ack), 32'd1);
      send_byte(ptr, ack);
      chk("rs_reg_ack", 32'(ack), 32'd1);
      ref_ptr = ptr;
      m_rstart();
    end
    send_byte({DEV, 1'b1}, ack);
    chk("raddr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(ref_ptr);
      recv_byte(d, i < n - 1);
      chk("rd_byte", 32'(d), 32'(ref_regs[ref_ptr]));
      if (i < n - 1) ref_ptr = ref_ptr + 8'd1;
    end
    m_stop(); wt(4);
    chk("rd_count", 32'(rd_q.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      chk("rd_addr", 32'(rd_q[i]), 32'(exp_rd[i]));
    chk("sda_idle", 32'(sda_oe), 32'd0);
  endtask

  task automatic chk_outputs_clear(input string tag);
    chk({tag, "_oe"}, 32'(sda_oe), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr"}, 32'({wr_en, rd_req}), 32'd0);
    chk({tag, "_addrs"}, 32'({wr_addr, wr_data, rd_addr}), 32'd0);
  endtask

  initial begin
    logic [7:0] dat [4];
    logic [7:0] b34;
    wr_prev = 1'b0;
    ref_ptr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      regs[i] = 8'($urandom);
      ref_regs[i] = regs[i];
    end
    #1;
    chk_outputs_clear("reset");
    wt(5);
    rst_n = 1'b1;
    wt(5);

    dat = '{8'h4A, 8'h00, 8'h00, 8'h00};
    do_write(DEV, 8'h0E, 1, dat, 1'b0);
    dat = '{8'h11, 8'h22, 8'h00, 8'h00};
    do_write(DEV, 8'hFF, 2, dat, 1'b0);
    dat = '{8'h4A, 8'h00, 8'h00, 8'h00};
    do_write(7'h1B, 8'h0E, 1, dat, 1'b0);

    regs[8'h05] = 8'hA5; ref_regs[8'h05] = 8'hA5;
    regs[8'h06] = 8'h3C; ref_regs[8'h06] = 8'h3C;
    do_read(1'b1, 8'h05, 2);

    dat = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_write(DEV, 8'h20, 0, dat, 1'b1);
    dat = '{8'h5E, 8'h00, 8'h00, 8'h00};
    do_write(DEV, 8'h21, 1, dat, 1'b0);
    do_read(1'b0, 8'h00, 1);

    for (int t = 0; t < 12; t++) begin
      logic [7:0] p;
      int n;
      for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
      p = ($urandom_range(3) == 0) ? 8'hFE : 8'($urandom);
      n = int'($urandom_range(4, 1));
      case ($urandom_range(4))
        0: do_write(DEV ^ 7'($urandom_range(127, 1)), p, n, dat, 1'b0);
        1, 2: do_write(DEV, p, n, dat, 1'b0);
        3: do_read(1'b1, p, n);
        default: do_read(1'b0, p, n);
      endcase
    end

    b34 = {DEV, 1'b0};
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(b34[i]);
    for (int k = 0; k < 40 && !sda_oe; k++) wt(1);
    chk("ack_pre_rst", 32'(sda_oe), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_clear("mid_ack_rst");
    wt(3);
    rst_n = 1'b1;
    ref_ptr = 8'h00;
    m_stop(); wt(4);
    do_read(1'b0, 8'h00, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h1A, the 7-bit target address the block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on scl_in and sda_in (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock, sampled on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port scl_in  input  1  raw SCL from the pad, asynchronous to clk.
REQ-006 SHALL have port sda_in  input  1  raw SDA from the pad, asynchronous to clk.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 SHALL have port wr_en  output  1  one-clk write strobe.
REQ-009 SHALL have port wr_addr  output  8  register address, valid while wr_en=1.
REQ-010 SHALL have port wr_data  output  8  register data, valid while wr_en=1.
REQ-011 SHALL have port rd_req  output  1  one-clk read request.
REQ-012 SHALL have port rd_addr  output  8  register address, valid while rd_req=1.
REQ-013 SHALL have port rd_data  input  8  read data, sampled on the clk cycle after rd_req.
REQ-014 SHALL have port busy  output  1  1 from an address-matched START until the next STOP or START.

Function
REQ-015 SHALL synchronize scl_in/sda_in through SYNC_STAGES flops and detect edges against one further history flop; all protocol logic SHALL use only the synchronized signals.
REQ-016 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-017 SHALL sample SDA on detected SCL rising edges, MSB first, and SHALL change sda_oe only on detected SCL falling edges, except at STOP/reset.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and WAIT.
REQ-019 SHALL enter ADDR on START or repeated START from any state, clearing the bit counter.
REQ-020 In ADDR, after 8 bits, SHALL go to ADDR_ACK if bits[7:1]==DEV_ADDR, else to WAIT with sda_oe held at 0.
REQ-021 In each ACK state, SHALL set sda_oe=1 at the SCL fall after the 8th bit and clear it at the next SCL fall.
REQ-022 After ADDR_ACK, if R/W=0, SHALL go to REG; the REG byte SHALL load the 8-bit register pointer; REG_ACK SHALL then go to WDATA.
REQ-023 Each completed WDATA byte SHALL pulse wr_en for exactly one clk, beginning the cycle after the 8th-bit SCL rise, with wr_addr=pointer and wr_data=byte.
REQ-024 After each WDATA byte, SHALL increment the pointer modulo 256 (8'hFF -> 8'h00); WDATA_ACK SHALL return to WDATA.
REQ-025 After ADDR_ACK, if R/W=1, SHALL pulse rd_req with rd_addr=pointer on the ACK-slot SCL rise, then load rd_data into the transmit shift register on the next clk.
REQ-026 In RDATA, SHALL drive sda_oe=~shift[7] from each SCL fall, shift on each SCL rise, and release SDA (sda_oe=0) at the SCL fall after the 8th bit.
REQ-027 In RDATA_ACK, SHALL sample the master ACK at the SCL rise; on ACK (0), SHALL increment the pointer, pulse rd_req for the new pointer, and return to RDATA; on NACK (1), SHALL go to WAIT.
REQ-028 The pointer SHALL persist across transactions, so that a write of the pointer followed by a repeated-START read targets that pointer.
REQ-029 On STOP in any state, SHALL go to IDLE on the next clk with sda_oe=0, busy=0, and no wr_en for the partial byte.
REQ-030 WAIT SHALL keep sda_oe=0 and leave only on START or STOP.
REQ-031 SHALL operate correctly when the SCL high and SCL low times are each >= 8 clk cycles.

Reset
REQ-032 Asserting rst_n low SHALL force state=IDLE, pointer=8'h00, sda_oe=0, wr_en=0, rd_req=0, busy=0, wr_addr=8'h00, wr_data=8'h00 and rd_addr=8'h00 immediately, including mid-byte and mid-ACK.
REQ-033 After rst_n deasserts, SHALL ignore bus activity until the first START, and synchronizer and history flops SHALL reset to 1.

Verification
REQ-034 START, 8'h34, 8'h0E, 8'h4A, STOP -> ACK (sda_oe=1) in all 3 slots; exactly one wr_en with wr_addr=8'h0E and wr_data=8'h4A.
REQ-035 START, 8'h34, 8'hFF, 8'h11, 8'h22, STOP -> wr_en at addresses 8'hFF then 8'h00 with data 8'h11 and 8'h22.
REQ-036 START, 8'h36, 8'h0E, 8'h4A, STOP -> sda_oe never 1, no wr_en, busy stays 0.
REQ-037 START, 8'h34, 8'h05, repeated START, 8'h35, rd_data=8'hA5 then 8'h3C, master ACK then NACK, STOP -> rd_req at rd_addr 8'h05 then 8'h06; SDA carries A5 then 3C.
REQ-038 STOP after 4 bits of a WDATA byte -> IDLE, no wr_en; a following write transaction completes normally.
REQ-039 rst_n low during the ADDR_ACK slot -> sda_oe=0 in the same cycle; pointer reads back as 8'h00 afterwards.
